// File: rtl/sextium_ram_avalon_pipe.sv
// Avalon-MM slave bridge onto a synchronous single-port RAM macro
// (altsyncram-style byteena/clocken/wren/rden). Reads are pipelined and
// qualified by readdatavalid; reset_req drains outstanding reads and then
// holds the RAM clock enable low until the request is withdrawn.
//
// MEM_LATENCY must be 1 or 2; DATA_W must be a multiple of 8.
module sextium_ram_avalon_pipe #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned OUT_REG     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  reset_req,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteena,
    output logic                  mem_clock,
    output logic                  mem_clocken,
    output logic [DATA_W-1:0]     mem_data,
    input  logic [DATA_W-1:0]     mem_q,
    output logic                  mem_wren,
    output logic                  mem_rden
);

    localparam int unsigned LAT   = MEM_LATENCY + OUT_REG;
    localparam int unsigned CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LAT-1:0]   r_valid;
    logic [CNT_W-1:0] w_outstanding;
    logic             w_wait;
    logic             w_clocken;
    logic             w_accept;
    logic             w_wr;
    logic             w_rd;

    // Number of reads still travelling through the valid pipeline
    always_comb begin
        w_outstanding = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            w_outstanding = w_outstanding + CNT_W'(r_valid[i]);
        end
    end

    // Next-state and back-pressure / RAM clock-enable decode
    always_comb begin
        w_state_nxt = r_state;
        w_wait      = 1'b1;
        w_clocken   = clken;
        case (r_state)
            ST_RUN: begin
                w_wait = ~clken;
                if (clken && reset_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Withdrawal of the request wins over an empty pipeline
                if (clken) begin
                    if (!reset_req) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_outstanding == '0) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                w_clocken = 1'b0;
                if (clken && !reset_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (reset) begin
            w_wait = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else if (clken) begin
            r_state <= w_state_nxt;
        end
    end

    // Transfer acceptance; a simultaneous read+write is treated as a write only
    assign w_accept = chipselect & ~w_wait;
    assign w_wr     = w_accept & write;
    assign w_rd     = w_accept & read & ~write;

    // Valid pipeline: one bit per accepted read, frozen while clken is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (clken) begin
            r_valid <= (r_valid << 1) | LAT'(w_rd);
        end
    end

    // Read data path: optional bridge-side register after the RAM output
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_readdata;
            logic              w_mem_vld;

            assign w_mem_vld = r_valid[MEM_LATENCY-1];

            // Capture RAM data as the read leaves the RAM pipeline
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_readdata <= '0;
                end else if (clken && w_mem_vld) begin
                    r_readdata <= mem_q;
                end
            end

            assign readdata = r_readdata;
        end else begin : g_no_out_reg
            assign readdata = reset ? '0 : mem_q;
        end
    endgenerate

    assign readdatavalid = clken & r_valid[LAT-1];
    assign waitrequest   = w_wait;

    // RAM side: address/data/byte enables pass straight through
    assign mem_clock   = clk;
    assign mem_clocken = w_clocken;
    assign mem_address = address;
    assign mem_byteena = byteenable;
    assign mem_data    = writedata;
    assign mem_wren    = w_wr;
    assign mem_rden    = w_rd;

endmodule

// File: doc/sextium_ram_avalon_pipe.md
Name: sextium_ram_avalon_pipe

Overview:
Parametrised Avalon-MM slave bridge onto a synchronous single-port on-chip RAM (altsyncram-style byteena/clocken/wren/rden interface). It succeeds the fixed 16-bit pass-through bridge and adds the following:
- Configurable data width, address width and RAM read latency.
- Optional output register.
- Pipelined reads with readdatavalid.
- waitrequest back-pressure.
- A reset_req drain/hold FSM that quiesces the RAM only after all outstanding reads have returned.

It sits between the Sextium III system interconnect and the RAM macro.

Parameters:
DATA_W, 16, data width in bits; multiple of 8
ADDR_W, 16, word address width
MEM_LATENCY, 1, RAM read latency in cycles (1 = address registered only, 2 = plus q register); legal values 1..2
OUT_REG, 0, 1 = register readdata in the bridge (adds 1 cycle)

Ports:
clk  in  1  system clock; also drives mem_clock
reset  in  1  asynchronous, active-high reset
clken  in  1  global clock enable; 0 freezes the bridge and the RAM
reset_req  in  1  request to quiesce the RAM (drain, then hold)
address  in  ADDR_W  Avalon word address
byteenable  in  DATA_W/8  Avalon byte enables
chipselect  in  1  Avalon select
read  in  1  Avalon read
write  in  1  Avalon write
writedata  in  DATA_W  Avalon write data
readdata  out  DATA_W  Avalon read data
readdatavalid  out  1  readdata qualifier, one pulse per accepted read
waitrequest  out  1  Avalon back-pressure
mem_address  out  ADDR_W  RAM address
mem_byteena  out  DATA_W/8  RAM byte enables
mem_clock  out  1  equals clk
mem_clocken  out  1  RAM clock enable
mem_data  out  DATA_W  RAM write data
mem_q  in  DATA_W  RAM read data
mem_wren  out  1  RAM write enable
mem_rden  out  1  RAM read enable

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous, active-high. All flops clear on reset.
- Reset values: readdata=0, readdatavalid=0, waitrequest=1 while reset is high, FSM=RUN, valid pipeline=0.
- Total read latency L = MEM_LATENCY + OUT_REG, counted from the acceptance edge to the cycle readdatavalid=1.
- Transfer acceptance: a transfer is accepted on a rising edge with chipselect=1, waitrequest=0 and clken=1.
  - write=1: mem_wren=1 in the same cycle; mem_address, mem_byteena and mem_data are combinational from the Avalon side.
  - read=1 and write=0: mem_rden=1; a 1 enters valid pipeline stage 0.
  - read=1 and write=1 (illegal): write wins; no read is tracked and readdatavalid is never produced for it.
  - mem_wren and mem_rden are forced to 0 whenever waitrequest=1.
- Valid pipeline: MEM_LATENCY+OUT_REG bits; shifts only when clken=1.
  - OUT_REG=0: readdata=mem_q combinational; readdatavalid=valid[MEM_LATENCY-1].
  - OUT_REG=1: readdata is registered from mem_q when valid[MEM_LATENCY-1]=1 and clken=1, and holds otherwise; readdatavalid=valid[L-1].
  - readdatavalid is 0 whenever clken=0. A frozen pipeline resumes exactly where it stopped.
- Throughput: one transfer per cycle. Back-to-back reads return in order on consecutive cycles. A read immediately after a write to the same address returns the new data, because the RAM performs write-before-read across edges.
- outstanding = count of 1s in the valid pipeline; at most L.
- FSM states:
  - RUN: waitrequest = ~clken; mem_clocken = clken. reset_req=1 -> DRAIN.
  - DRAIN: waitrequest=1; no new transfers; mem_clocken = clken. Pipeline empty (outstanding=0) -> HOLD. reset_req=0 -> RUN; this takes priority over the empty condition in the same cycle.
  - HOLD: waitrequest=1; mem_clocken=0; mem_wren=mem_rden=0. reset_req=0 -> RUN.
- reset_req asserted on the same edge as an accepted transfer: the transfer is accepted, because waitrequest was still 0 in that cycle. Its read data must return during DRAIN.
- FSM transitions occur only when clken=1.
- Reset asserted mid-read: in-flight reads are discarded. No readdatavalid appears after reset deasserts.

Test Plan:
- DATA_W=16, MEM_LATENCY=1, OUT_REG=0: write 0xBEEF to addr 0x0010 with byteenable=2'b11, then read addr 0x0010 -> readdatavalid exactly 1 cycle after acceptance with readdata=0xBEEF.
- Byte enables: write 0x1234 to addr 5, then write 0xAB00 with byteenable=2'b10, then read addr 5 -> 0xAB34.
- MEM_LATENCY=2, OUT_REG=1: reads on 4 consecutive cycles to addrs 0..3 holding 0x0A..0x0D -> readdatavalid high for 4 consecutive cycles starting 3 cycles after the first accept, data in order.
- Drain: issue a read, raise reset_req on the same edge -> waitrequest=1 the next cycle, mem_clocken stays 1 until the readdatavalid pulse, then mem_clocken=0 (HOLD); drop reset_req -> waitrequest=0 the next cycle.
- clken stall: issue a read, then clken=0 for 3 cycles -> readdatavalid=0, mem_clocken=0, waitrequest=1 throughout; data returns L clken-active cycles after accept.
- Reset mid-operation: assert reset with 2 reads in flight -> readdata=0 and readdatavalid=0 immediately; no stray readdatavalid after release; simultaneous read+write writes the data and yields no readdatavalid.
